// File: rtl/program_counter_if.sv
// Fetch-address bus between the sequencer (master) and the program counter (slave).
interface program_counter_if #(
  parameter int unsigned ADDR_SIZE   = 19,
  parameter int unsigned STACK_DEPTH = 8
);
  localparam int unsigned CNT_W = $clog2(STACK_DEPTH) + 1;

  logic                 stall;
  logic                 jump;
  logic                 call;
  logic                 ret;
  logic                 clear_err;
  logic [ADDR_SIZE-1:0] in_address;
  logic [ADDR_SIZE-1:0] out_address;
  logic                 pc_valid;
  logic [CNT_W-1:0]     stack_count;
  logic                 stack_overflow;
  logic                 stack_underflow;

  modport master (
    output stall, jump, call, ret, clear_err, in_address,
    input  out_address, pc_valid, stack_count, stack_overflow, stack_underflow
  );

  modport slave (
    input  stall, jump, call, ret, clear_err, in_address,
    output out_address, pc_valid, stack_count, stack_overflow, stack_underflow
  );
endinterface

// File: rtl/program_counter.sv
// Fetch-address register with priority ret > call > jump > increment.
// Define PC_CALL_STACK_EN to build the return-address stack and its sticky error flags.
module program_counter #(
  parameter int unsigned          ADDR_SIZE    = 19,
  parameter int unsigned          STACK_DEPTH  = 8,
  parameter logic [ADDR_SIZE-1:0] RESET_VECTOR = '0
) (
  input  logic              clk,
  input  logic              rst,
  program_counter_if.slave  bus
);

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  state_t               state;
  logic [ADDR_SIZE-1:0] pc_q;
  logic [ADDR_SIZE-1:0] pc_inc;
  logic                 active;

  assign pc_inc = pc_q + ADDR_SIZE'(1);
  assign active = (state == ST_RUN) && !bus.stall;

  assign bus.out_address = pc_q;
  assign bus.pc_valid    = (state == ST_RUN);

`ifdef PC_CALL_STACK_EN
  localparam int unsigned PTR_W = $clog2(STACK_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ADDR_SIZE-1:0] stack_mem [STACK_DEPTH];
  logic [CNT_W-1:0]     count_q;
  logic [PTR_W-1:0]     top_idx;
  logic                 ovf_q;
  logic                 unf_q;
  logic                 full;
  logic                 empty;
  logic                 do_push;

  assign full    = (count_q == CNT_W'(STACK_DEPTH));
  assign empty   = (count_q == '0);
  // At full occupancy the low pointer bits are zero, so top_idx wraps to DEPTH-1.
  assign top_idx = count_q[PTR_W-1:0] - PTR_W'(1);

  always_comb begin
    do_push = active && !bus.ret && bus.call && !full;
  end

  // Storage needs no reset; occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) begin
      stack_mem[count_q[PTR_W-1:0]] <= pc_inc;
    end
  end

  assign bus.stack_count     = count_q;
  assign bus.stack_overflow  = ovf_q;
  assign bus.stack_underflow = unf_q;
`else
  logic unused_ctrl;

  assign unused_ctrl         = &{1'b0, bus.ret, bus.clear_err};
  assign bus.stack_count     = '0;
  assign bus.stack_overflow  = 1'b0;
  assign bus.stack_underflow = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_INIT;
      pc_q    <= RESET_VECTOR;
`ifdef PC_CALL_STACK_EN
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
`endif
    end else if (state == ST_INIT) begin
      // First edge out of reset only raises pc_valid; the reset vector is fetched once.
      state <= ST_RUN;
    end else begin
`ifdef PC_CALL_STACK_EN
      // Clear first so a same-edge overflow/underflow assignment below takes precedence.
      if (bus.clear_err) begin
        ovf_q <= 1'b0;
        unf_q <= 1'b0;
      end
      if (!bus.stall) begin
        if (bus.ret) begin
          if (empty) begin
            unf_q <= 1'b1;
          end else begin
            pc_q    <= stack_mem[top_idx];
            count_q <= count_q - CNT_W'(1);
          end
        end else if (bus.call) begin
          pc_q <= bus.in_address;
          if (full) begin
            ovf_q <= 1'b1;
          end else begin
            count_q <= count_q + CNT_W'(1);
          end
        end else if (bus.jump) begin
          pc_q <= bus.in_address;
        end else begin
          pc_q <= pc_inc;
        end
      end
`else
      if (!bus.stall) begin
        if (bus.call || bus.jump) begin
          pc_q <= bus.in_address;
        end else begin
          pc_q <= pc_inc;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_program_counter.sv
// Directed self-checking bench for program_counter; expectations follow PC_CALL_STACK_EN.
module tb_program_counter;
  localparam int unsigned AW    = 19;
  localparam int unsigned DEPTH = 8;
`ifdef PC_CALL_STACK_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   fails  = 0;

  program_counter_if #(.ADDR_SIZE(AW), .STACK_DEPTH(DEPTH)) bus ();

  program_counter #(
    .ADDR_SIZE   (AW),
    .STACK_DEPTH (DEPTH),
    .RESET_VECTOR(19'h00000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_controls();
    bus.stall      = 1'b0;
    bus.jump       = 1'b0;
    bus.call       = 1'b0;
    bus.ret        = 1'b0;
    bus.clear_err  = 1'b0;
    bus.in_address = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_controls();
    tick();
    tick();
    checks++; if (bus.out_address !== 19'h00000) begin fails++; $display("FAIL reset_addr: got %h expected %h", bus.out_address, 19'h00000); end
    checks++; if (bus.pc_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", bus.pc_valid); end
    checks++; if (bus.stack_count !== 4'd0) begin fails++; $display("FAIL reset_count: got %0d expected 0", bus.stack_count); end
    checks++; if (bus.stack_overflow !== 1'b0) begin fails++; $display("FAIL reset_ovf: got %b expected 0", bus.stack_overflow); end
    checks++; if (bus.stack_underflow !== 1'b0) begin fails++; $display("FAIL reset_unf: got %b expected 0", bus.stack_underflow); end
    rst = 1'b0;
    tick();
    checks++; if (bus.pc_valid !== 1'b1) begin fails++; $display("FAIL first_valid: got %b expected 1", bus.pc_valid); end
    checks++; if (bus.out_address !== 19'h00000) begin fails++; $display("FAIL first_addr: got %h expected %h", bus.out_address, 19'h00000); end
    tick();
    checks++; if (bus.out_address !== 19'h00001) begin fails++; $display("FAIL inc1: got %h expected %h", bus.out_address, 19'h00001); end
    tick();
    checks++; if (bus.out_address !== 19'h00002) begin fails++; $display("FAIL inc2: got %h expected %h", bus.out_address, 19'h00002); end
  endtask

  task automatic test_jump_wrap();
    bus.jump = 1'b1; bus.in_address = 19'h7FFFF;
    tick();
    bus.jump = 1'b0;
    checks++; if (bus.out_address !== 19'h7FFFF) begin fails++; $display("FAIL jump_max: got %h expected %h", bus.out_address, 19'h7FFFF); end
    tick();
    checks++; if (bus.out_address !== 19'h00000) begin fails++; $display("FAIL wrap0: got %h expected %h", bus.out_address, 19'h00000); end
    tick();
    checks++; if (bus.out_address !== 19'h00001) begin fails++; $display("FAIL wrap1: got %h expected %h", bus.out_address, 19'h00001); end
  endtask

  task automatic test_call_ret();
    bus.jump = 1'b1; bus.in_address = 19'h00010;
    tick();
    bus.jump = 1'b0;
    checks++; if (bus.out_address !== 19'h00010) begin fails++; $display("FAIL cr_start: got %h expected %h", bus.out_address, 19'h00010); end
    bus.call = 1'b1; bus.in_address = 19'h00100;
    tick();
    bus.call = 1'b0;
    checks++; if (bus.out_address !== 19'h00100) begin fails++; $display("FAIL call_target: got %h expected %h", bus.out_address, 19'h00100); end
    checks++; if (bus.stack_count !== (STK ? 4'd1 : 4'd0)) begin fails++; $display("FAIL call_count: got %0d expected %0d", bus.stack_count, STK ? 1 : 0); end
    tick();
    checks++; if (bus.out_address !== 19'h00101) begin fails++; $display("FAIL sub_inc1: got %h expected %h", bus.out_address, 19'h00101); end
    tick();
    checks++; if (bus.out_address !== 19'h00102) begin fails++; $display("FAIL sub_inc2: got %h expected %h", bus.out_address, 19'h00102); end
    bus.ret = 1'b1;
    tick();
    bus.ret = 1'b0;
    checks++; if (bus.out_address !== (STK ? 19'h00011 : 19'h00103)) begin fails++; $display("FAIL ret_addr: got %h expected %h", bus.out_address, STK ? 19'h00011 : 19'h00103); end
    checks++; if (bus.stack_count !== 4'd0) begin fails++; $display("FAIL ret_count: got %0d expected 0", bus.stack_count); end
  endtask

  task automatic test_overflow();
    logic [AW-1:0] exp_addr;
    int            exp_cnt;
    bus.jump = 1'b1; bus.in_address = 19'h00200;
    tick();
    bus.jump = 1'b0;
    for (int i = 0; i < 9; i++) begin
      bus.call = 1'b1; bus.in_address = AW'(32'h1000 + i);
      tick();
      exp_cnt = STK ? ((i + 1 > 8) ? 8 : i + 1) : 0;
      checks++; if (bus.stack_count !== 4'(exp_cnt)) begin fails++; $display("FAIL fill_count[%0d]: got %0d expected %0d", i, bus.stack_count, exp_cnt); end
    end
    bus.call = 1'b0;
    checks++; if (bus.out_address !== 19'h01008) begin fails++; $display("FAIL ovf_target: got %h expected %h", bus.out_address, 19'h01008); end
    checks++; if (bus.stack_overflow !== STK) begin fails++; $display("FAIL ovf_flag: got %b expected %b", bus.stack_overflow, STK); end
    bus.clear_err = 1'b1;
    tick();
    bus.clear_err = 1'b0;
    checks++; if (bus.stack_overflow !== 1'b0) begin fails++; $display("FAIL ovf_clear: got %b expected 0", bus.stack_overflow); end
    checks++; if (bus.out_address !== 19'h01009) begin fails++; $display("FAIL clear_inc: got %h expected %h", bus.out_address, 19'h01009); end
    bus.call = 1'b1; bus.clear_err = 1'b1; bus.in_address = 19'h03000;
    tick();
    bus.call = 1'b0; bus.clear_err = 1'b0;
    checks++; if (bus.stack_overflow !== STK) begin fails++; $display("FAIL ovf_beats_clear: got %b expected %b", bus.stack_overflow, STK); end
    checks++; if (bus.out_address !== 19'h03000) begin fails++; $display("FAIL ovf2_target: got %h expected %h", bus.out_address, 19'h03000); end
    for (int j = 0; j < 8; j++) begin
      bus.ret = 1'b1;
      tick();
      if (STK) exp_addr = (j < 7) ? AW'(32'h1007 - j) : 19'h00201;
      else     exp_addr = AW'(32'h3001 + j);
      exp_cnt = STK ? 7 - j : 0;
      checks++; if (bus.out_address !== exp_addr) begin fails++; $display("FAIL pop_addr[%0d]: got %h expected %h", j, bus.out_address, exp_addr); end
      checks++; if (bus.stack_count !== 4'(exp_cnt)) begin fails++; $display("FAIL pop_count[%0d]: got %0d expected %0d", j, bus.stack_count, exp_cnt); end
    end
    bus.ret = 1'b0;
  endtask

  task automatic test_underflow();
    bus.jump = 1'b1; bus.clear_err = 1'b1; bus.in_address = 19'h00020;
    tick();
    bus.jump = 1'b0; bus.clear_err = 1'b0;
    checks++; if (bus.out_address !== 19'h00020) begin fails++; $display("FAIL unf_start: got %h expected %h", bus.out_address, 19'h00020); end
    bus.ret = 1'b1;
    tick();
    bus.ret = 1'b0;
    checks++; if (bus.out_address !== (STK ? 19'h00020 : 19'h00021)) begin fails++; $display("FAIL unf_hold: got %h expected %h", bus.out_address, STK ? 19'h00020 : 19'h00021); end
    checks++; if (bus.stack_underflow !== STK) begin fails++; $display("FAIL unf_flag: got %b expected %b", bus.stack_underflow, STK); end
    bus.clear_err = 1'b1;
    tick();
    bus.clear_err = 1'b0;
    checks++; if (bus.stack_underflow !== 1'b0) begin fails++; $display("FAIL unf_clear: got %b expected 0", bus.stack_underflow); end
    bus.call = 1'b1; bus.in_address = 19'h00500;
    tick();
    bus.call = 1'b0;
    checks++; if (bus.out_address !== 19'h00500) begin fails++; $display("FAIL call2_target: got %h expected %h", bus.out_address, 19'h00500); end
    bus.ret = 1'b1; bus.jump = 1'b1; bus.in_address = 19'h00600;
    tick();
    bus.ret = 1'b0; bus.jump = 1'b0;
    checks++; if (bus.out_address !== (STK ? 19'h00022 : 19'h00600)) begin fails++; $display("FAIL ret_over_jump: got %h expected %h", bus.out_address, STK ? 19'h00022 : 19'h00600); end
    checks++; if (bus.stack_count !== 4'd0) begin fails++; $display("FAIL ret_jump_count: got %0d expected 0", bus.stack_count); end
  endtask

  task automatic test_stall();
    logic [AW-1:0] hold;
    bit            exp_unf;
    hold = STK ? 19'h00022 : 19'h00601;
    bus.ret = 1'b1;
    tick();
    bus.ret = 1'b0;
    checks++; if (bus.out_address !== hold) begin fails++; $display("FAIL pre_stall: got %h expected %h", bus.out_address, hold); end
    checks++; if (bus.stack_underflow !== STK) begin fails++; $display("FAIL pre_stall_unf: got %b expected %b", bus.stack_underflow, STK); end
    bus.stall = 1'b1; bus.jump = 1'b1; bus.in_address = 19'h00400;
    for (int k = 0; k < 3; k++) begin
      bus.clear_err = (k == 2);
      tick();
      exp_unf = STK && (k < 2);
      checks++; if (bus.out_address !== hold) begin fails++; $display("FAIL stall_hold[%0d]: got %h expected %h", k, bus.out_address, hold); end
      checks++; if (bus.stack_underflow !== exp_unf) begin fails++; $display("FAIL stall_unf[%0d]: got %b expected %b", k, bus.stack_underflow, exp_unf); end
    end
    bus.clear_err = 1'b0; bus.stall = 1'b0;
    tick();
    bus.jump = 1'b0;
    checks++; if (bus.out_address !== 19'h00400) begin fails++; $display("FAIL unstall_jump: got %h expected %h", bus.out_address, 19'h00400); end
  endtask

  task automatic test_async_reset();
    bus.call = 1'b1; bus.in_address = 19'h00700;
    tick();
    checks++; if (bus.stack_count !== (STK ? 4'd1 : 4'd0)) begin fails++; $display("FAIL prerst_count: got %0d expected %0d", bus.stack_count, STK ? 1 : 0); end
    bus.in_address = 19'h00780;
    #2;
    rst = 1'b1;
    #1;
    checks++; if (bus.out_address !== 19'h00000) begin fails++; $display("FAIL arst_addr: got %h expected %h", bus.out_address, 19'h00000); end
    checks++; if (bus.pc_valid !== 1'b0) begin fails++; $display("FAIL arst_valid: got %b expected 0", bus.pc_valid); end
    checks++; if (bus.stack_count !== 4'd0) begin fails++; $display("FAIL arst_count: got %0d expected 0", bus.stack_count); end
    checks++; if (bus.stack_overflow !== 1'b0) begin fails++; $display("FAIL arst_ovf: got %b expected 0", bus.stack_overflow); end
    bus.call = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    checks++; if (bus.pc_valid !== 1'b1) begin fails++; $display("FAIL rerun_valid: got %b expected 1", bus.pc_valid); end
    bus.ret = 1'b1;
    tick();
    bus.ret = 1'b0;
    checks++; if (bus.out_address !== (STK ? 19'h00000 : 19'h00001)) begin fails++; $display("FAIL post_rst_ret: got %h expected %h", bus.out_address, STK ? 19'h00000 : 19'h00001); end
    checks++; if (bus.stack_underflow !== STK) begin fails++; $display("FAIL post_rst_unf: got %b expected %b", bus.stack_underflow, STK); end
  endtask

  initial begin
    test_reset();
    test_jump_wrap();
    test_call_ret();
    test_overflow();
    test_underflow();
    test_stall();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/program_counter.md
# program_counter

Instruction-address source for the 19-bit CPU: holds the current fetch address and drives it onto the address bus `pc` modport as `out_address`. It accepts branch targets on `in_address` and advances sequentially or redirects on jump/call/return. A return-address stack supports nested subroutine calls.

## Interface
Parameters:
- `ADDR_SIZE`, default `ADDR_SIZE` from `constants` (19): address width.
- `STACK_DEPTH`, default 8: return-stack entries, power of two, ≥2.
- `RESET_VECTOR`, default 0: fetch address after reset.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `stall`  in  1  hold all state; `jump`/`call`/`ret` ignored this cycle.
- `jump`  in  1  load `in_address` into PC.
- `call`  in  1  push PC+1, load `in_address`.
- `ret`  in  1  pop stack top into PC.
- `clear_err`  in  1  clear sticky error flags.
- `in_address`  in  ADDR_SIZE  branch/call target (bus `in_address`).
- `out_address`  out  ADDR_SIZE  current fetch address (bus `out_address`).
- `pc_valid`  out  1  `out_address` valid for fetch.
- `stack_count`  out  $clog2(STACK_DEPTH)+1  occupied entries.
- `stack_overflow`  out  1  sticky: call while full.
- `stack_underflow`  out  1  sticky: ret while empty.

## Operation
- Reset values: `out_address`=RESET_VECTOR, `pc_valid`=0, `stack_count`=0, both flags 0; stack contents don't-care.
- Per unstalled edge, exactly one action, priority `ret` > `call` > `jump` > increment.
- Increment: PC ← PC+1 mod 2^ADDR_SIZE; 0x7FFFF → 0x00000.
- Jump: PC ← `in_address`.
- Call, not full: mem[count] ← PC+1 (wrapped), count+1, PC ← `in_address`.
- Call, full (count=STACK_DEPTH): PC ← `in_address`, no push, count unchanged, `stack_overflow` ← 1.
- Ret, not empty: PC ← mem[count-1], count-1.
- Ret, empty: PC holds, `stack_underflow` ← 1.
- `stall`=1: PC, stack, count, flags hold; `clear_err` still honoured.
- `clear_err`: flags ← 0 on that edge; a same-edge overflow/underflow event wins (flag ends 1).
- Stack is LIFO; no wrap of pointer, occupancy saturates at 0 and STACK_DEPTH.

## Timing
- All outputs registered; change only on `clk` rising edge or asynchronous `rst` assertion.
- `pc_valid` rises on first rising edge after `rst` deasserts, stays 1 until next reset; PC does not advance on that edge (it holds RESET_VECTOR for one valid cycle).
- Latency: control sampled at edge N → new `out_address` visible after edge N; one-cycle redirect, no bubbles inserted.
- `rst` mid-call/ret: state returns to reset values immediately; pending push/pop discarded.
- Controls are level-sampled per edge; upstream must hold them through stall.

## Configuration
- `PC_CALL_STACK_EN` defined: return stack, `call`/`ret` and both flags as above.
- Undefined: no stack storage; `call` behaves as `jump` (no push); `ret` ignored (increment taken if no other control); `stack_count`, `stack_overflow`, `stack_underflow` tied 0.

## Test plan
- Reset, release, no controls → `out_address` 0x00000 one cycle with `pc_valid`=1, then 0x00001, 0x00002.
- `jump` with `in_address`=0x7FFFF, then idle two cycles → 0x7FFFF, 0x00000, 0x00001.
- At PC 0x00010 `call` to 0x00100, idle 2, `ret` → 0x00100, 0x00101, 0x00102, 0x00011; `stack_count` 1 then 0.
- 9 consecutive `call`s (STACK_DEPTH=8) → `stack_count`=8, `stack_overflow`=1 after 9th, PC = 9th target; `clear_err` → flag 0.
- `ret` with empty stack at PC 0x00020 → PC stays 0x00020, `stack_underflow`=1; `ret`+`jump` same edge with one entry → pop wins.
- `stall`=1 with `jump` 0x00400 for 3 cycles → PC unchanged; assert `rst` during `call` → all outputs reset asynchronously.
